// File: rtl/phv_arb_pkg.sv
// Shared types for the PHV round-robin arbiter: output-slot state and statistics width.
package phv_arb_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    PHV_ONLY,
    VLAN_ONLY
  } slot_state_e;

  localparam int unsigned STAT_W = 32;

endpackage

// File: rtl/phv_rr_arbiter_if.sv
// Handshake bundle between PHV/VLAN sources, the arbiter and match-action stage 0.
// Statistics signals exist only when PHV_ARB_STATS_EN is defined.
interface phv_rr_arbiter_if #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned PHV_LEN        = 1024,
  parameter int unsigned C_VLANID_WIDTH = 12,
  parameter int unsigned PORT_W         = $clog2(NUM_PORTS)
);
  import phv_arb_pkg::*;

  logic [NUM_PORTS*PHV_LEN-1:0]        phv_in;
  logic [NUM_PORTS-1:0]                phv_in_valid;
  logic [NUM_PORTS*C_VLANID_WIDTH-1:0] vlan_in;
  logic [NUM_PORTS-1:0]                vlan_in_valid;
  logic [NUM_PORTS-1:0]                in_ready;
  logic [PHV_LEN-1:0]                  phv_out;
  logic                                phv_out_valid;
  logic                                stage_ready_in;
  logic [C_VLANID_WIDTH-1:0]           vlan_out;
  logic                                vlan_valid_out;
  logic                                vlan_ready_in;
  logic [PORT_W-1:0]                   grant_port;
`ifdef PHV_ARB_STATS_EN
  logic [NUM_PORTS*STAT_W-1:0]         stat_grant_cnt;
  logic [STAT_W-1:0]                   stat_stall_cnt;
`endif

  // master: the arbiter itself; slave: sources plus stage (environment side)
  modport master (
    input  phv_in, phv_in_valid, vlan_in, vlan_in_valid, stage_ready_in, vlan_ready_in,
    output in_ready, phv_out, phv_out_valid, vlan_out, vlan_valid_out, grant_port
`ifdef PHV_ARB_STATS_EN
    , output stat_grant_cnt, stat_stall_cnt
`endif
  );

  modport slave (
    output phv_in, phv_in_valid, vlan_in, vlan_in_valid, stage_ready_in, vlan_ready_in,
    input  in_ready, phv_out, phv_out_valid, vlan_out, vlan_valid_out, grant_port
`ifdef PHV_ARB_STATS_EN
    , input stat_grant_cnt, stat_stall_cnt
`endif
  );

endinterface

// File: rtl/phv_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last+1, wrapping.
module rr_pick #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last,
  output logic [NUM_PORTS-1:0] gnt_onehot,
  output logic [PORT_W-1:0]    gnt_idx,
  output logic                 any
);

  logic [PORT_W-1:0] cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = PORT_W'((32'(last) + k) % NUM_PORTS);
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phv_rr_arbiter.sv
// Round-robin arbiter feeding stage 0 with an atomically paired PHV + VLAN slot.
// Optional per-port grant and stall counters are built when PHV_ARB_STATS_EN is defined.
module phv_rr_arbiter
  import phv_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned PHV_LEN        = 1024,
  parameter int unsigned C_VLANID_WIDTH = 12,
  parameter int unsigned PORT_W         = $clog2(NUM_PORTS)
) (
  input  logic                axis_clk,
  input  logic                aresetn,
  phv_rr_arbiter_if.master    bus
);

  slot_state_e               state;
  logic [PHV_LEN-1:0]        phv_q;
  logic [C_VLANID_WIDTH-1:0] vlan_q;
  logic                      phv_v_q;
  logic                      vlan_v_q;
  logic [PORT_W-1:0]         grant_q;
  logic [PORT_W-1:0]         last_grant;

  logic [NUM_PORTS-1:0]      req;
  logic [NUM_PORTS-1:0]      gnt_onehot;
  logic [PORT_W-1:0]         gnt_idx;
  logic                      any;
  logic                      phv_take;
  logic                      vlan_take;
  logic                      slot_free;
  logic                      accept;
  logic [PHV_LEN-1:0]        win_phv;
  logic [C_VLANID_WIDTH-1:0] win_vlan;

  assign req       = bus.phv_in_valid & bus.vlan_in_valid;
  assign phv_take  = phv_v_q & bus.stage_ready_in;
  assign vlan_take = vlan_v_q & bus.vlan_ready_in;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req        (req),
    .last       (last_grant),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // Free also covers the cycle in which the last pending half drains, enabling same-cycle refill
  always_comb begin
    slot_free = 1'b0;
    case (state)
      EMPTY:     slot_free = 1'b1;
      FULL:      slot_free = phv_take & vlan_take;
      PHV_ONLY:  slot_free = phv_take;
      VLAN_ONLY: slot_free = vlan_take;
      default:   slot_free = 1'b1;
    endcase
  end

  assign accept       = aresetn & slot_free & any;
  assign bus.in_ready = accept ? gnt_onehot : '0;

  always_comb begin
    win_phv  = '0;
    win_vlan = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt_onehot[p]) begin
        win_phv  = bus.phv_in[p*PHV_LEN +: PHV_LEN];
        win_vlan = bus.vlan_in[p*C_VLANID_WIDTH +: C_VLANID_WIDTH];
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state      <= EMPTY;
      phv_q      <= '0;
      vlan_q     <= '0;
      phv_v_q    <= 1'b0;
      vlan_v_q   <= 1'b0;
      grant_q    <= '0;
      last_grant <= PORT_W'(NUM_PORTS - 1);
    end else if (slot_free) begin
      if (any) begin
        state      <= FULL;
        phv_q      <= win_phv;
        vlan_q     <= win_vlan;
        phv_v_q    <= 1'b1;
        vlan_v_q   <= 1'b1;
        grant_q    <= gnt_idx;
        last_grant <= gnt_idx;
      end else begin
        state    <= EMPTY;
        phv_v_q  <= 1'b0;
        vlan_v_q <= 1'b0;
      end
    end else begin
      case (state)
        FULL: begin
          if (phv_take) begin
            state   <= VLAN_ONLY;
            phv_v_q <= 1'b0;
          end else if (vlan_take) begin
            state    <= PHV_ONLY;
            vlan_v_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.phv_out        = phv_q;
  assign bus.vlan_out       = vlan_q;
  assign bus.phv_out_valid  = phv_v_q;
  assign bus.vlan_valid_out = vlan_v_q;
  assign bus.grant_port     = grant_q;

`ifdef PHV_ARB_STATS_EN
  logic [NUM_PORTS-1:0][STAT_W-1:0] grant_cnt;
  logic [STAT_W-1:0]                stall_cnt;

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (accept && gnt_onehot[p]) grant_cnt[p] <= grant_cnt[p] + 1'b1;
      end
      if (state != EMPTY && any && !slot_free) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.stat_grant_cnt = grant_cnt;
  assign bus.stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_phv_rr_arbiter.sv
// Directed bench for phv_rr_arbiter with a per-cycle behavioural slot model and literal pins.
module tb_phv_rr_arbiter;
  import phv_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned PL = 1024;
  localparam int unsigned VW = 12;
  localparam int unsigned PW = 2;

  logic axis_clk = 1'b0;
  logic aresetn  = 1'b0;
  always #5 axis_clk = ~axis_clk;

  phv_rr_arbiter_if #(.NUM_PORTS(N), .PHV_LEN(PL), .C_VLANID_WIDTH(VW), .PORT_W(PW)) bus ();

  phv_rr_arbiter #(.NUM_PORTS(N), .PHV_LEN(PL), .C_VLANID_WIDTH(VW), .PORT_W(PW)) dut (
    .axis_clk (axis_clk),
    .aresetn  (aresetn),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Per-port data changes every cycle so held/loaded values are distinguishable
  int unsigned cyc = 0;
  always @(posedge axis_clk) begin
    #1;
    cyc++;
    for (int i = 0; i < int'(N); i++) begin
      bus.phv_in[i*PL +: PL]  = {32{16'(cyc), 16'(i)}};
      bus.vlan_in[i*VW +: VW] = VW'(cyc * 4 + i);
    end
  end

  // Model: the slot is two pending flags; free means nothing left pending after this cycle's consumes
  logic          m_pv, m_vv, n_pv, n_vv;
  logic [PL-1:0] m_phv, n_phv;
  logic [VW-1:0] m_vlan, n_vlan;
  int unsigned   m_port, m_last, n_port, n_last, win, p;
  logic          found, cp, cv, free, rst_s, push;
  logic [N-1:0]  exp_ready;
  bit            armed = 0;
  int unsigned   win_log[$];

  initial forever begin
    @(negedge axis_clk);
    rst_s = aresetn;
    found = 1'b0;
    win   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      p = (m_last + k) % N;
      if (!found && bus.phv_in_valid[p] && bus.vlan_in_valid[p]) begin
        found = 1'b1;
        win   = p;
      end
    end
    cp        = m_pv && bus.stage_ready_in;
    cv        = m_vv && bus.vlan_ready_in;
    free      = !((m_pv && !cp) || (m_vv && !cv));
    exp_ready = (rst_s && free && found) ? (N'(1) << win) : '0;
    if (armed) begin
      chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      chk("phv_out_valid", 64'(bus.phv_out_valid), 64'(m_pv));
      chk("vlan_valid_out", 64'(bus.vlan_valid_out), 64'(m_vv));
      chk("grant_port", 64'(bus.grant_port), 64'(m_port));
      if (m_pv) begin
        checks++;
        if (bus.phv_out !== m_phv) begin
          errors++;
          $display("FAIL phv_out actual=%0h expected=%0h", bus.phv_out[63:0], m_phv[63:0]);
        end
      end
      if (m_vv) chk("vlan_out", 64'(bus.vlan_out), 64'(m_vlan));
    end
    n_pv = m_pv && !cp;  n_vv = m_vv && !cv;
    n_phv = m_phv;  n_vlan = m_vlan;  n_port = m_port;  n_last = m_last;
    push = 1'b0;
    if (free && found) begin
      n_pv = 1'b1;  n_vv = 1'b1;
      n_phv  = bus.phv_in[win*PL +: PL];
      n_vlan = bus.vlan_in[win*VW +: VW];
      n_port = win;  n_last = win;  push = 1'b1;
    end
    @(posedge axis_clk);
    if (!rst_s) begin
      m_pv = 1'b0;  m_vv = 1'b0;  m_phv = '0;  m_vlan = '0;
      m_port = 0;  m_last = N - 1;  armed = 1;
    end else if (armed) begin
      m_pv = n_pv;  m_vv = n_vv;  m_phv = n_phv;  m_vlan = n_vlan;
      m_port = n_port;  m_last = n_last;
      if (push) win_log.push_back(n_port);
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_valid(input logic [N-1:0] pv, input logic [N-1:0] vv);
    bus.phv_in_valid  = pv;
    bus.vlan_in_valid = vv;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    set_valid('0, '0);
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  int unsigned exp_ord [6] = '{0, 1, 2, 3, 0, 1};
  int unsigned cnt [N];
  logic [VW-1:0] exp_v;

  initial begin
    bus.phv_in = '0;
    bus.vlan_in = '0;
    set_valid('0, '0);
    bus.stage_ready_in = 1'b1;
    bus.vlan_ready_in  = 1'b1;
    tick();
    tick();
    settle();
    chk("rst_phv_valid", 64'(bus.phv_out_valid), 64'd0);
    chk("rst_vlan_valid", 64'(bus.vlan_valid_out), 64'd0);
    chk("rst_grant", 64'(bus.grant_port), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_phv_out", bus.phv_out[63:0], 64'd0);
    chk("rst_vlan_out", 64'(bus.vlan_out), 64'd0);
    aresetn = 1'b1;

    // single source on port 2, back to back
    set_valid(4'b0100, 4'b0100);
    settle();
    chk("t1_ready0", 64'(bus.in_ready), 64'b0100);
    chk("t1_lat0", 64'(bus.phv_out_valid), 64'd0);
    tick(); settle();
    chk("t1_lat1_phv", 64'(bus.phv_out_valid), 64'd1);
    chk("t1_lat1_vlan", 64'(bus.vlan_valid_out), 64'd1);
    chk("t1_grant", 64'(bus.grant_port), 64'd2);
    repeat (5) begin
      tick(); settle();
      chk("t1_ready", 64'(bus.in_ready), 64'b0100);
      chk("t1_grant_bb", 64'(bus.grant_port), 64'd2);
    end

    // all four ports, 100 grants
    do_reset();
    win_log.delete();
    set_valid(4'b1111, 4'b1111);
    repeat (100) tick();
    set_valid('0, '0);
    chk("t2_total", 64'(win_log.size()), 64'd100);
    if (win_log.size() >= 6)
      for (int i = 0; i < 6; i++) chk("t2_order", 64'(win_log[i]), 64'(exp_ord[i]));
    for (int i = 0; i < int'(N); i++) cnt[i] = 0;
    foreach (win_log[i]) cnt[win_log[i]]++;
    for (int i = 0; i < int'(N); i++) chk("t2_share", 64'(cnt[i]), 64'd25);

    // split consume: PHV taken, VLAN held for 3 cycles
    tick();
    set_valid(4'b0010, 4'b0010);
    settle();
    exp_v = VW'(cyc * 4 + 1);
    tick(); settle();
    chk("t3_grant", 64'(bus.grant_port), 64'd1);
    chk("t3_vlan", 64'(bus.vlan_out), 64'(exp_v));
    bus.vlan_ready_in = 1'b0;
    settle();
    chk("t3_noready_full", 64'(bus.in_ready), 64'd0);
    repeat (3) begin
      tick(); settle();
      chk("t3_phv_gone", 64'(bus.phv_out_valid), 64'd0);
      chk("t3_vlan_pend", 64'(bus.vlan_valid_out), 64'd1);
      chk("t3_vlan_held", 64'(bus.vlan_out), 64'(exp_v));
      chk("t3_no_grant", 64'(bus.in_ready), 64'd0);
    end
    bus.vlan_ready_in = 1'b1;
    settle();
    chk("t3_refill_ready", 64'(bus.in_ready), 64'b0010);
    tick(); settle();
    chk("t3_refill_phv", 64'(bus.phv_out_valid), 64'd1);
    chk("t3_refill_grant", 64'(bus.grant_port), 64'd1);

    // port 3 with PHV only never requests
    set_valid(4'b1000, 4'b0000);
    tick();
    repeat (4) begin
      settle();
      chk("t4_half_valid", 64'(bus.in_ready), 64'd0);
      chk("t4_empty", 64'(bus.phv_out_valid), 64'd0);
      tick();
    end
    bus.vlan_in_valid = 4'b1000;
    settle();
    chk("t4_ready", 64'(bus.in_ready), 64'b1000);
    tick(); settle();
    chk("t4_grant", 64'(bus.grant_port), 64'd3);

    // reset while PHV_ONLY
    set_valid(4'b0001, 4'b0001);
    tick(); settle();
    chk("t5_grant0", 64'(bus.grant_port), 64'd0);
    set_valid('0, '0);
    bus.stage_ready_in = 1'b0;
    tick(); settle();
    chk("t5_phv_pend", 64'(bus.phv_out_valid), 64'd1);
    chk("t5_vlan_gone", 64'(bus.vlan_valid_out), 64'd0);
    aresetn = 1'b0;
    set_valid(4'b1001, 4'b1001);
    settle();
    chk("t5_ready_in_rst", 64'(bus.in_ready), 64'd0);
    tick(); settle();
    chk("t5_rst_phv", 64'(bus.phv_out_valid), 64'd0);
    chk("t5_rst_vlan", 64'(bus.vlan_valid_out), 64'd0);
    chk("t5_rst_grant", 64'(bus.grant_port), 64'd0);
    aresetn = 1'b1;
    bus.stage_ready_in = 1'b1;
    settle();
    chk("t5_first", 64'(bus.in_ready), 64'b0001);
    tick(); settle();
    chk("t5_first_grant", 64'(bus.grant_port), 64'd0);
    tick(); settle();
    chk("t5_wrap_next", 64'(bus.grant_port), 64'd3);

`ifdef PHV_ARB_STATS_EN
    do_reset();
    set_valid(4'b0011, 4'b0011);
    bus.stage_ready_in = 1'b0;
    bus.vlan_ready_in  = 1'b0;
    tick();
    repeat (10) tick();
    settle();
    chk("st_stall", 64'(bus.stat_stall_cnt), 64'd10);
    chk("st_grant0", 64'(bus.stat_grant_cnt[31:0]), 64'd1);
    force dut.grant_cnt = {N{32'hFFFF_FFFF}};
    #1;
    release dut.grant_cnt;
    bus.stage_ready_in = 1'b1;
    bus.vlan_ready_in  = 1'b1;
    tick(); settle();
    chk("st_wrap1", 64'(bus.stat_grant_cnt[63:32]), 64'd0);
    chk("st_hold0", 64'(bus.stat_grant_cnt[31:0]), 64'hFFFF_FFFF);
    bus.stage_ready_in = 1'b1;
`endif

    set_valid('0, '0);
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
